// File: rtl/pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard/forwarding controller.
package pipe_pkg;

    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       set_flags;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
    } ex_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       set_flags;
    } mem_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
    } wb_slot_t;

    // The MEM producer is newer than WB, so it wins when both match.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_EXMEM;
        if (wb_hit)  return FWD_MEMWB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard request and controller response bundle.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rn;
    logic [4:0]       id_rm;
    logic             id_use_rn;
    logic             id_use_rm;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_set_flags;
    logic             id_cbz;
    logic             id_bcond;
    logic             id_br_taken;

    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_bubble;
    logic             ifid_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       cbz_fwd;
    logic             flag_fwd;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_cbz, id_bcond, id_br_taken,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b,
               cbz_fwd, flag_fwd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
               id_reg_write, id_mem_read, id_set_flags, id_cbz, id_bcond, id_br_taken,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b,
               cbz_fwd, flag_fwd, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_match.sv
// Single producer/consumer register compare: a hit means the consumer must
// wait for or take a bypass from this producer.
module reg_match
    import pipe_pkg::*;
#(
    parameter logic [4:0] ZR = XZR
) (
    input  logic       vld,
    input  logic       wr,
    input  logic [4:0] dst,
    input  logic       src_used,
    input  logic [4:0] src,
    output logic       hit
);
    assign hit = vld & wr & src_used & (dst != ZR) & (dst == src);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and forwarding control for the 5-stage LEGv8 pipeline.
// Shadows EX/MEM/WB destinations and resolves ID- and EX-stage operands from them.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 32,
    parameter logic [4:0]  XZR   = 5'd31
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);
    import pipe_pkg::*;

    localparam int NCMP = 8;

    ex_slot_t             ex_q;
    mem_slot_t            mem_q;
    wb_slot_t             wb_q;
    logic [NCMP-1:0]      c_vld, c_wr, c_use, c_hit;
    logic [NCMP-1:0][4:0] c_dst, c_src;
    logic                 load_use, cbz_hz, stall, flush;
    fwd_sel_t             fwd_a, fwd_b, cbz_fwd;
    logic [CNT_W-1:0]     stall_cnt, flush_cnt;
    logic                 unused;

    // Compare index: 0 id_rn/EX, 1 id_rm/EX, 2 id_rm/MEM, 3 id_rm/WB,
    //                4 ex.rn/MEM, 5 ex.rn/WB, 6 ex.rm/MEM, 7 ex.rm/WB
    assign c_vld = {wb_q.valid, mem_q.valid, wb_q.valid, mem_q.valid,
                    wb_q.valid, mem_q.valid, ex_q.valid, ex_q.valid};
    assign c_wr  = {wb_q.reg_write, mem_q.reg_write, wb_q.reg_write, mem_q.reg_write,
                    wb_q.reg_write, mem_q.reg_write, ex_q.reg_write, ex_q.reg_write};
    assign c_dst = {wb_q.rd, mem_q.rd, wb_q.rd, mem_q.rd,
                    wb_q.rd, mem_q.rd, ex_q.rd, ex_q.rd};
    assign c_src = {ex_q.rm, ex_q.rm, ex_q.rn, ex_q.rn,
                    hz.id_rm, hz.id_rm, hz.id_rm, hz.id_rn};
    assign c_use = {{2{ex_q.valid & ex_q.use_rm}}, {2{ex_q.valid & ex_q.use_rn}},
                    {3{hz.id_use_rm}}, hz.id_use_rn};

    for (genvar i = 0; i < NCMP; i++) begin : g_cmp
        reg_match #(.ZR(XZR)) u_match (
            .vld      (c_vld[i]),
            .wr       (c_wr[i]),
            .dst      (c_dst[i]),
            .src_used (c_use[i]),
            .src      (c_src[i]),
            .hit      (c_hit[i])
        );
    end

    // CBZ resolves in ID, so any EX producer or a load still in MEM must drain first.
    assign load_use = ex_q.mem_read & (c_hit[0] | c_hit[1]);
    assign cbz_hz   = hz.id_cbz & (c_hit[1] | (mem_q.mem_read & c_hit[2]));
    assign stall    = hz.id_valid & (load_use | cbz_hz);
    assign flush    = hz.id_valid & (hz.id_cbz | hz.id_bcond) & hz.id_br_taken & ~stall;

    assign fwd_a   = fwd_pick(c_hit[4], c_hit[5]);
    assign fwd_b   = fwd_pick(c_hit[6], c_hit[7]);
    assign cbz_fwd = (hz.id_valid & hz.id_cbz & ~stall)
                   ? fwd_pick(c_hit[2] & ~mem_q.mem_read, c_hit[3]) : FWD_REG;

    assign hz.pc_stall    = stall;
    assign hz.ifid_stall  = stall;
    assign hz.idex_bubble = stall;
    assign hz.ifid_flush  = flush;
    assign hz.fwd_a       = fwd_a;
    assign hz.fwd_b       = fwd_b;
    assign hz.cbz_fwd     = cbz_fwd;
    assign hz.flag_fwd    = hz.id_valid & hz.id_bcond & ex_q.valid & ex_q.set_flags;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.flush_cnt   = flush_cnt;

    // Flags are consumed only from EX; the MEM copy is kept for debug visibility.
    assign unused = mem_q.set_flags;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_q  <= '{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
            mem_q <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write,
                       mem_read: ex_q.mem_read, set_flags: ex_q.set_flags};
            ex_q  <= '{valid: hz.id_valid & ~stall, rd: hz.id_rd,
                       reg_write: hz.id_reg_write, mem_read: hz.id_mem_read,
                       set_flags: hz.id_set_flags, rn: hz.id_rn, rm: hz.id_rm,
                       use_rn: hz.id_use_rn, use_rm: hz.id_use_rm};
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
